// File: rtl/add_share_arbiter.sv
// add_share_arbiter: round-robin arbiter in front of a shared add/subtract unit
// with a single registered result slot and an accepted-transaction counter.
`default_nettype none

module add_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           txn_count
);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;
    logic             slot_free;
    logic             transfer;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   result;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign slot_free = !rsp_valid || rsp_ready;
    // Gated by rst so no handshake can be seen while reset is held.
    assign transfer  = !rst && slot_free && grant_any;
    assign req_ready = transfer ? (NREQ'(1) << grant_idx) : '0;

    assign op_a   = req_a[grant_idx*WIDTH +: WIDTH];
    assign op_b   = req_b[grant_idx*WIDTH +: WIDTH];
    // The extra MSB is carry-out on add and borrow on subtract.
    assign result = req_op[grant_idx] ? ({1'b0, op_a} - {1'b0, op_b})
                                      : ({1'b0, op_a} + {1'b0, op_b});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
            ptr       <= '0;
            txn_count <= '0;
        end else begin
            if (transfer) begin
                rsp_valid <= 1'b1;
                rsp_sum   <= result[WIDTH-1:0];
                rsp_carry <= result[WIDTH];
                rsp_id    <= grant_idx;
                ptr       <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                txn_count <= txn_count + 16'd1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_add_share_arbiter.sv
// tb_add_share_arbiter: vector table, directed corner sequences and randomized
// traffic checked against a transaction-level reference model.
`default_nettype none

module tb_add_share_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0] req_op = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;
    logic         rsp_carry;
    logic [1:0]   rsp_id;
    logic [15:0]  txn_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   m_ptr = 0;
    bit   m_valid = 0;
    int   m_sum = 0;
    bit   m_carry = 0;
    int   m_id = 0;
    int   m_cnt = 0;

    add_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] vld);
        for (int k = 0; k < N; k++)
            if (vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0;
    endtask

    // Apply inputs, check the handshake, clock once, then check the result slot.
    task automatic cycle(input logic [N-1:0] vld, input logic [N*W-1:0] a,
                         input logic [N*W-1:0] b, input logic [N-1:0] op, input bit rr);
        int  g;
        int  av, bv;
        bit  free;
        logic [N-1:0] exp_ready;
        req_valid = vld; req_a = a; req_b = b; req_op = op; rsp_ready = rr;
        #1;
        free = !m_valid || rr;
        g = free ? model_grant(vld) : -1;
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        if (g >= 0) begin
            av = int'(a[g*W +: W]);
            bv = int'(b[g*W +: W]);
            if (op[g]) begin
                m_sum = (av - bv + 256) % 256;
                m_carry = av < bv;
            end else begin
                m_sum = (av + bv) % 256;
                m_carry = (av + bv) > 255;
            end
            m_valid = 1; m_id = g;
            m_ptr = (g + 1) % N;
            m_cnt = (m_cnt + 1) % 65536;
        end else if (m_valid && rr) begin
            m_valid = 0;
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
            chk("rsp_carry", 32'(rsp_carry), 32'(m_carry));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        chk("txn_count", 32'(txn_count), 32'(m_cnt));
    endtask

    typedef struct {
        int         req;
        bit         op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sum;
        bit         exp_carry;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [N*W-1:0] a, b;
        logic [7:0]     held_sum;
        logic [1:0]     held_id;

        vecs[0] = '{0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[1] = '{1, 1'b0, 8'hFF, 8'h02, 8'h01, 1'b1};
        vecs[2] = '{2, 1'b1, 8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[3] = '{3, 1'b1, 8'h05, 8'h03, 8'h02, 1'b0};
        vecs[4] = '{0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{2, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[6] = '{1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[7] = '{3, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1};

        // Reset state
        req_valid = 4'b1111;
        #12;
        chk("reset req_ready", 32'(req_ready), 32'h0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset txn_count", 32'(txn_count), 32'h0);
        chk("reset rsp_sum", 32'(rsp_sum), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Directed vector table, one lone request each
        for (int i = 0; i < 8; i++) begin
            a = '0; b = '0;
            a[vecs[i].req*W +: W] = vecs[i].a;
            b[vecs[i].req*W +: W] = vecs[i].b;
            cycle(N'(1) << vecs[i].req, a, b, N'(vecs[i].op) << vecs[i].req, 1'b1);
            chk("vec sum", 32'(rsp_sum), 32'(vecs[i].exp_sum));
            chk("vec carry", 32'(rsp_carry), 32'(vecs[i].exp_carry));
            chk("vec id", 32'(rsp_id), 32'(vecs[i].req));
            if (i == 0) chk("first txn_count", 32'(txn_count), 32'h1);
        end
        cycle('0, '0, '0, '0, 1'b1);

        // Round-robin with all requesters held valid
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 32'h04030201, 32'h01010101, 4'b0000, 1'b1);
            chk("rr id", 32'(rsp_id), 32'(i % N));
        end
        cycle('0, '0, '0, '0, 1'b1);

        // Backpressure: pending result from requester 1, then 0011 stalled
        cycle(4'b0010, 32'h00002200, 32'h00001100, 4'b0000, 1'b0);
        held_sum = rsp_sum; held_id = rsp_id;
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0011, 32'h00005566, 32'h00000102, 4'b0000, 1'b0);
            chk("stall sum", 32'(rsp_sum), 32'(held_sum));
            chk("stall id", 32'(rsp_id), 32'(held_id));
        end
        cycle(4'b0011, 32'h00005566, 32'h00000102, 4'b0000, 1'b1);
        chk("post-stall grant", 32'(rsp_id), 32'h0);
        cycle('0, '0, '0, '0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(N'($urandom), $urandom, $urandom, N'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset with a result pending
        cycle(4'b0001, 32'h00000033, 32'h00000011, 4'b0000, 1'b0);
        chk("pre-reset valid", 32'(rsp_valid), 32'h1);
        req_valid = 4'b0100;
        #2;
        rst = 1'b1;
        #1;
        chk("async rsp_valid", 32'(rsp_valid), 32'h0);
        chk("async txn_count", 32'(txn_count), 32'h0);
        chk("async rsp_sum", 32'(rsp_sum), 32'h0);
        chk("async req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(4'b0100, 32'h00090000, 32'h00040000, 4'b0100, 1'b1);
        chk("post-reset id", 32'(rsp_id), 32'h2);
        chk("post-reset sum", 32'(rsp_sum), 32'h5);

        // Counter wrap
        while (m_cnt != 16'hFFFF) begin
            cycle(4'b1111, 32'h01020304, 32'h01010101, 4'b1010, 1'b1);
        end
        cycle(4'b1111, 32'h01020304, 32'h01010101, 4'b1010, 1'b1);
        chk("wrap txn_count", 32'(txn_count), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/add_share_arbiter.md
ADD_SHARE_ARBITER -- requirements
Module: add_share_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters; NREQ is 2..8.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port req_valid, input, NREQ: bit i high means requester i presents an operation.
REQ-006 Port req_ready, output, NREQ: bit i high means requester i's operation is accepted this cycle.
REQ-007 Port req_a, input, NREQ*WIDTH: operand A; requester i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-008 Port req_b, input, NREQ*WIDTH: operand B, packed like req_a.
REQ-009 Port req_op, input, NREQ: per-requester operation; 0 = add, 1 = subtract.
REQ-010 Port rsp_valid, output, 1: a result is held on the rsp_* outputs.
REQ-011 Port rsp_ready, input, 1: the consumer accepts the result this cycle.
REQ-012 Port rsp_sum, output, WIDTH: the result modulo 2^WIDTH.
REQ-013 Port rsp_carry, output, 1: carry-out on add; borrow on subtract (1 when A < B unsigned).
REQ-014 Port rsp_id, output, ceil(log2(NREQ)): index of the requester that owns the result.
REQ-015 Port txn_count, output, 16: count of accepted operations, wrapping at 2^16.

Function
REQ-016 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high at the clock edge.
REQ-017 The slot is free (slot_free) when rsp_valid is 0, or when rsp_valid and rsp_ready are both 1 in the same cycle.
REQ-018 req_ready SHALL be one-hot or all-zero, decoded combinationally from req_valid, the priority pointer and slot_free; it SHALL be all-zero when slot_free is 0.
REQ-019 Arbitration SHALL be round-robin: the grant goes to the first requester with req_valid high, searching from index ptr upward and wrapping modulo NREQ.
REQ-020 After a transfer to requester g, ptr SHALL become (g+1) mod NREQ; without a transfer, ptr SHALL hold.
REQ-021 On a transfer, the next edge SHALL load the output registers as follows: rsp_sum = A+B or A-B modulo 2^WIDTH; rsp_carry as in REQ-013; rsp_id = g; rsp_valid = 1. This gives one-cycle latency.
REQ-022 If rsp_valid and rsp_ready are both high and no new transfer occurs, rsp_valid SHALL clear at the next edge; rsp_sum, rsp_carry and rsp_id may hold stale values.
REQ-023 While rsp_valid is 1 and rsp_ready is 0, rsp_sum, rsp_carry and rsp_id SHALL hold stable.
REQ-024 Simultaneous drain and accept SHALL give back-to-back results: sustained throughput is one operation per cycle with rsp_ready tied high.
REQ-025 txn_count SHALL increment by 1 on each transfer and wrap from 0xFFFF to 0x0000.
REQ-026 Requesters SHALL keep their operands stable while valid and not ready; the block samples operands only at the transfer edge.
REQ-027 A deasserted request SHALL never be granted. A requester that stays valid SHALL be granted within NREQ transfers.

Reset
REQ-028 While rst is high, rsp_valid, rsp_sum, rsp_carry, rsp_id, ptr and txn_count SHALL be 0, and req_ready SHALL be all-zero, regardless of clk.
REQ-029 If rst asserts while a result is pending, the result SHALL be discarded with no output glitch to rsp_valid = 1.
REQ-030 After rst deasserts, the first edge SHALL accept a request normally, starting with ptr = 0.

Verification
REQ-031 Single request: req_valid=0001, A=0x7F, B=0x01, op=0, rsp_ready=1 -> next cycle rsp_valid=1, sum=0x80, carry=0, id=0, txn_count=1.
REQ-032 Carry and borrow: add 0xFF+0x02 -> sum 0x01, carry 1. Subtract 0x03-0x05 -> sum 0xFE, carry 1. Subtract 0x05-0x03 -> sum 0x02, carry 0.
REQ-033 Round-robin: req_valid=1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,... over consecutive cycles, one result per cycle.
REQ-034 Backpressure: rsp_ready=0 with a result pending and req_valid=0011 -> req_ready=0000; outputs stay stable for 5 cycles. When rsp_ready rises, the pending result drains and the next grant goes to the requester after the last one granted.
REQ-035 Reset mid-operation: assert rst asynchronously between edges with rsp_valid=1 -> rsp_valid, txn_count and rsp_sum read 0 immediately. After release, requester 2 alone is granted on the first edge.
REQ-036 Wrap: preload 65535 transfers (or force the counter to 0xFFFF) -> the next transfer gives txn_count=0x0000.
